// File: rtl/pio_irq_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pio_irq_sequencer
//  Purpose  : Avalon-MM master that services an edge-capture PIO on irq.
//             It programs the irq mask, reads edge_capture and data, clears
//             the serviced edges, and queues timestamped event records in a
//             first-word fall-through FIFO drained over valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
module pio_irq_sequencer #(
    parameter int             W         = 4,
    parameter int             DEPTH     = 4,
    parameter int             TS_W      = 16,
    parameter logic [W-1:0]   MASK_INIT = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    output logic [1:0]        m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [31:0]       m_writedata,
    input  logic [31:0]       m_readdata,
    input  logic              pio_irq,
    input  logic [W-1:0]      cfg_mask,
    input  logic              cfg_mask_wr,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [W-1:0]      ev_edges,
    output logic [W-1:0]      ev_level,
    output logic [TS_W-1:0]   ev_ts,
    output logic [7:0]        spurious_cnt
);

    localparam int         c_AW = $clog2(DEPTH);
    localparam int         c_EW = 2 * W + TS_W;
    localparam logic [c_AW:0] c_FULL = DEPTH[c_AW:0];

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_WR_MASK = 3'd1;
    localparam logic [2:0] c_ST_RD_EC   = 3'd2;
    localparam logic [2:0] c_ST_RD_DAT  = 3'd3;
    localparam logic [2:0] c_ST_CLR     = 3'd4;
    localparam logic [2:0] c_ST_PUSH    = 3'd5;

    localparam logic [1:0] c_ADDR_DATA = 2'd0;
    localparam logic [1:0] c_ADDR_MASK = 2'd2;
    localparam logic [1:0] c_ADDR_EC   = 2'd3;

    logic [2:0]        r_state;
    logic [TS_W-1:0]   r_ts;
    logic [TS_W-1:0]   r_ts_lat;
    logic [W-1:0]      r_mask;
    logic              r_mask_pend;
    logic [W-1:0]      r_ec;
    logic [W-1:0]      r_lvl;
    logic [7:0]        r_spur;
    logic [c_EW-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic [W-1:0]      w_rd_bits;
    logic              w_unused_rd;

    // Only the low W bits of the PIO registers carry information.
    assign w_rd_bits    = m_readdata[W-1:0];
    assign w_unused_rd  = ^m_readdata[31:W];

    assign w_full       = (r_count == c_FULL);
    assign w_push       = (r_state == c_ST_PUSH);
    assign w_pop        = ev_valid & ev_ready;
    assign ev_valid     = (r_count != '0);
    assign {ev_edges, ev_level, ev_ts} = r_mem[r_rd_ptr];
    assign spurious_cnt = r_spur;

    // Free-running timestamp, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) r_ts <= '0;
        else       r_ts <= r_ts + 1'b1;
    end

    // Mask request latch; a pulse during WR_MASK keeps the request alive.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask      <= MASK_INIT;
            r_mask_pend <= 1'b1;
        end else if (cfg_mask_wr) begin
            r_mask      <= cfg_mask;
            r_mask_pend <= 1'b1;
        end else if (r_state == c_ST_WR_MASK) begin
            r_mask_pend <= 1'b0;
        end
    end

    // Service sequencer: mask write has priority, irq only accepted with FIFO room.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_ts_lat <= '0;
            r_ec     <= '0;
            r_lvl    <= '0;
            r_spur   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (r_mask_pend) begin
                        r_state <= c_ST_WR_MASK;
                    end else if (pio_irq && !w_full) begin
                        r_ts_lat <= r_ts;
                        r_state  <= c_ST_RD_EC;
                    end
                end
                c_ST_WR_MASK: r_state <= c_ST_IDLE;
                c_ST_RD_EC:   r_state <= c_ST_RD_DAT;
                c_ST_RD_DAT: begin
                    // m_readdata now holds edge_capture from the RD_EC address.
                    r_ec <= w_rd_bits;
                    if (w_rd_bits == '0) begin
                        if (r_spur != 8'hFF) r_spur <= r_spur + 8'd1;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_state <= c_ST_CLR;
                    end
                end
                c_ST_CLR: begin
                    // m_readdata now holds the port level from the RD_DAT address.
                    r_lvl   <= w_rd_bits;
                    r_state <= c_ST_PUSH;
                end
                c_ST_PUSH:    r_state <= c_ST_IDLE;
                default:      r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Bus outputs decoded from the current state.
    always_comb begin
        m_chipselect = 1'b0;
        m_write_n    = 1'b1;
        m_address    = c_ADDR_DATA;
        m_writedata  = '0;
        case (r_state)
            c_ST_WR_MASK: begin
                m_chipselect         = 1'b1;
                m_write_n            = 1'b0;
                m_address            = c_ADDR_MASK;
                m_writedata[W-1:0]   = r_mask;
            end
            c_ST_RD_EC: begin
                m_chipselect = 1'b1;
                m_address    = c_ADDR_EC;
            end
            c_ST_RD_DAT: begin
                m_chipselect = 1'b1;
                m_address    = c_ADDR_DATA;
            end
            c_ST_CLR: begin
                m_chipselect         = 1'b1;
                m_write_n            = 1'b0;
                m_address            = c_ADDR_EC;
                m_writedata[W-1:0]   = r_ec;
            end
            default: ;
        endcase
    end

    // Event FIFO storage.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {r_ec, r_lvl, r_ts_lat};
    end

    // Event FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pio_irq_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pio_irq_sequencer
//  Purpose  : Directed self-checking bench with a behavioural edge-capture
//             PIO attached to the master port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pio_irq_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    logic        pio_irq;
    logic [3:0]  cfg_mask;
    logic        cfg_mask_wr;
    logic        ev_valid;
    logic        ev_ready;
    logic [3:0]  ev_edges;
    logic [3:0]  ev_level;
    logic [15:0] ev_ts;
    logic [7:0]  spurious_cnt;

    always #5 clk = ~clk;

    pio_irq_sequencer #(.W(4), .DEPTH(4), .TS_W(16), .MASK_INIT(4'hF)) dut (
        .clk(clk), .reset(reset),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
        .m_writedata(m_writedata), .m_readdata(m_readdata),
        .pio_irq(pio_irq), .cfg_mask(cfg_mask), .cfg_mask_wr(cfg_mask_wr),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_edges(ev_edges),
        .ev_level(ev_level), .ev_ts(ev_ts), .spurious_cnt(spurious_cnt)
    );

    // Behavioural edge-capture PIO (not reset by the sequencer reset).
    logic [3:0]  pio_in    = 4'd0;
    logic [3:0]  pio_in_d  = 4'd0;
    logic [3:0]  pio_ec    = 4'd0;
    logic [3:0]  pio_mask  = 4'd0;
    logic [31:0] pio_rd    = 32'd0;
    logic        irq_force = 1'b0;
    logic        w_wr;

    assign w_wr       = m_chipselect && !m_write_n;
    assign m_readdata = pio_rd;
    assign pio_irq    = irq_force | (|(pio_ec & pio_mask));

    always @(posedge clk) begin
        pio_in_d <= pio_in;
        case (m_address)
            2'd0:    pio_rd <= {28'd0, pio_in};
            2'd2:    pio_rd <= {28'd0, pio_mask};
            2'd3:    pio_rd <= {28'd0, pio_ec};
            default: pio_rd <= 32'd0;
        endcase
        if (w_wr && m_address == 2'd2) pio_mask <= m_writedata[3:0];
        pio_ec <= (pio_ec | (pio_in & ~pio_in_d)) &
                  ~((w_wr && m_address == 2'd3) ? m_writedata[3:0] : 4'd0);
    end

    // Cycle count since reset release, the reference for timestamps.
    int cyc = 0;
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Bus and event monitors sample on the falling edge.
    logic [34:0] bus_q [$];
    logic [7:0]  ev_q  [$];
    always @(negedge clk) begin
        if (!reset) begin
            if (m_chipselect)
                bus_q.push_back({~m_write_n, m_address, m_write_n ? 32'd0 : m_writedata});
            if (ev_valid && ev_ready)
                ev_q.push_back({ev_edges, ev_level});
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [34:0] ent(input logic wr, input logic [1:0] a, input logic [31:0] d);
        return {wr, a, d};
    endfunction

    function automatic logic [34:0] bus_at(input int i);
        if (i < bus_q.size()) return bus_q[i];
        return '1;
    endfunction

    function automatic int count_wr(input logic [1:0] a);
        int n = 0;
        foreach (bus_q[i]) if (bus_q[i][34] && bus_q[i][33:32] == a) n++;
        return n;
    endfunction

    // Advance to just after the next falling edge(s).
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_irq(output logic found);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1);
            if (pio_irq) found = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    logic [3:0] pats [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
    logic [7:0] drain [4] = '{8'h22, 8'h44, 8'h88, 8'h50};
    logic       found;
    int         exp_ts;

    initial begin
        reset = 1'b1; ev_ready = 1'b0; cfg_mask = 4'd0; cfg_mask_wr = 1'b0;

        // Reset state and the initial mask write.
        step(3);
        check("rst_cs",   m_chipselect, 1'b0);
        check("rst_wn",   m_write_n,    1'b1);
        check("rst_addr", m_address,    2'd0);
        check("rst_wd",   m_writedata,  32'd0);
        check("rst_evv",  ev_valid,     1'b0);
        check("rst_spur", spurious_cnt, 8'd0);
        reset = 1'b0;
        step(10);
        check("init_nbus", bus_q.size(), 1);
        check("init_wr2",  bus_at(0), ent(1'b1, 2'd2, 32'hF));
        check("init_mask", pio_mask, 4'hF);

        // Basic service of edges 0101 with latency and timestamp.
        bus_q.delete(); ev_q.delete(); ev_ready = 1'b1;
        pio_in = 4'b0101;
        wait_irq(found);
        check("t2_irq", found, 1'b1);
        exp_ts = cyc;
        step(4);
        check("t2_lat4", ev_valid, 1'b0);
        step(1);
        check("t2_lat5",  ev_valid, 1'b1);
        check("t2_edges", ev_edges, 4'h5);
        check("t2_level", ev_level, 4'h5);
        check("t2_ts",    ev_ts, exp_ts[15:0]);
        step(2);
        check("t2_nbus", bus_q.size(), 3);
        check("t2_b0",   bus_at(0), ent(1'b0, 2'd3, 32'd0));
        check("t2_b1",   bus_at(1), ent(1'b0, 2'd0, 32'd0));
        check("t2_b2",   bus_at(2), ent(1'b1, 2'd3, 32'h5));
        check("t2_nev",  ev_q.size(), 1);
        check("t2_evv",  ev_valid, 1'b0);
        check("t2_ec",   pio_ec, 4'h0);

        // FIFO full: four events queue, the fifth waits for space.
        ev_ready = 1'b0; pio_in = 4'd0; step(2); bus_q.delete();
        for (int i = 0; i < 4; i++) begin
            pio_in = pats[i]; step(8); pio_in = 4'd0; step(2);
        end
        pio_in = 4'h1; step(3); pio_in = 4'd0; step(1);
        pio_in = 4'h4; step(3); pio_in = 4'd0; step(20);
        check("t3_nbus",  bus_q.size(), 12);
        check("t3_irq",   pio_irq, 1'b1);
        check("t3_ec",    pio_ec, 4'h5);
        check("t3_head",  {ev_valid, ev_edges, ev_level}, {1'b1, 8'h11});
        ev_ready = 1'b1; step(1); ev_ready = 1'b0; step(12);
        check("t3_nbus5", bus_q.size(), 15);
        check("t3_clr5",  bus_at(14), ent(1'b1, 2'd3, 32'h5));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_drain%0d", i), {ev_valid, ev_edges, ev_level}, {1'b1, drain[i]});
            ev_ready = 1'b1; step(1); ev_ready = 1'b0;
        end
        check("t3_empty", ev_valid, 1'b0);

        // Spurious irqs and counter saturation.
        bus_q.delete();
        irq_force = 1'b1; step(1); irq_force = 1'b0; step(6);
        check("t4_spur1", spurious_cnt, 8'd1);
        check("t4_nbus",  bus_q.size(), 2);
        check("t4_b0",    bus_at(0), ent(1'b0, 2'd3, 32'd0));
        check("t4_b1",    bus_at(1), ent(1'b0, 2'd0, 32'd0));
        check("t4_evv",   ev_valid, 1'b0);
        irq_force = 1'b1; step(30);
        check("t4_spur11", spurious_cnt, 8'd11);
        step(880); irq_force = 1'b0; step(5);
        check("t4_sat",  spurious_cnt, 8'd255);
        check("t4_nowr", count_wr(2'd3) + count_wr(2'd2), 0);

        // Mask rewrites during a service collapse to one later write.
        bus_q.delete(); ev_ready = 1'b1; pio_in = 4'h2;
        wait_irq(found);
        check("t5_irq", found, 1'b1);
        cfg_mask = 4'h3; cfg_mask_wr = 1'b1; step(1); cfg_mask_wr = 1'b0; step(1);
        cfg_mask = 4'h1; cfg_mask_wr = 1'b1; step(1); cfg_mask_wr = 1'b0; step(10);
        check("t5_nbus", bus_q.size(), 4);
        check("t5_b2",   bus_at(2), ent(1'b1, 2'd3, 32'h2));
        check("t5_b3",   bus_at(3), ent(1'b1, 2'd2, 32'h1));
        check("t5_mask", pio_mask, 4'h1);
        pio_in = 4'd0; step(2);

        // Reset in place of the clear write; service resumes after the mask write.
        bus_q.delete(); ev_q.delete(); pio_in = 4'h1;
        wait_irq(found);
        check("t6_irq", found, 1'b1);
        step(2);
        check("t6_rddat", {m_chipselect, m_write_n, m_address}, 4'b1100);
        reset = 1'b1; step(2);
        check("t6_rst_cs",   m_chipselect, 1'b0);
        check("t6_rst_spur", spurious_cnt, 8'd0);
        check("t6_noclr",    count_wr(2'd3), 0);
        check("t6_ec_kept",  pio_ec, 4'h1);
        bus_q.delete(); reset = 1'b0; step(12);
        check("t6_nbus", bus_q.size(), 4);
        check("t6_b0",   bus_at(0), ent(1'b1, 2'd2, 32'hF));
        check("t6_b1",   bus_at(1), ent(1'b0, 2'd3, 32'd0));
        check("t6_b3",   bus_at(3), ent(1'b1, 2'd3, 32'h1));
        check("t6_nev",  ev_q.size(), 1);
        check("t6_ev",   (ev_q.size() > 0) ? ev_q[0] : 8'hFF, 8'h11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
